// File: rtl/sweep_sched_if.sv
// sweep_sched_if: valid/ready write port into the downstream sweep buffer.
interface sweep_sched_if;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        wr_ready;
  modport master (output wr_valid, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/sweep_sched.sv
// sweep_sched: decides which sweeps are recorded and writes header + in-window samples
// of each recorded sweep into the sweep buffer.
module sweep_sched #(
  parameter int DATA_W = 12,
  parameter int RNG_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cfg_sector_mask,
  input  logic [RNG_W-1:0]  cfg_rng_first,
  input  logic [RNG_W-1:0]  cfg_rng_last,
  input  logic              cfg_load,
  input  logic [3:0]        sector,
  input  logic [DATA_W-1:0] bear,
  input  logic              north,
  input  logic              pros,
  input  logic [RNG_W-1:0]  range,
  input  logic              adc_dv,
  input  logic [DATA_W-1:0] adc_data,
  sweep_sched_if.master     wr,
  output logic [15:0]       sweep_cnt,
  output logic [7:0]        drop_cnt,
  output logic              ovf,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, CAPT, CLOSE, SKIP} state_t;
  state_t r_state, w_state;
  logic r_pros_q, r_dv, r_cfg_pend, r_close_pend, w_close_pend;
  logic r_valid, w_valid, r_wlast, w_wlast, r_ovf, w_ovf, w_inc;
  logic [RNG_W-1:0] r_rng, r_first, r_last;
  logic [DATA_W-1:0] r_adc, r_bear_l;
  logic [15:0] r_mask, r_data, w_data, r_sweep_cnt;
  logic [7:0] r_drop_cnt;
  logic w_start, w_hs, w_free, w_inwin, w_closing, w_idle;
  assign w_start   = pros & ~r_pros_q;
  assign w_idle    = r_state == IDLE;
  assign w_hs      = r_valid & wr.wr_ready;
  assign w_free    = ~r_valid | w_hs;
  assign w_inwin   = r_dv & (r_rng >= r_first) & (r_rng <= r_last);
  // r_pros_q is aligned with the registered sample, so a fall never overtakes a sample
  assign w_closing = ~r_pros_q | r_close_pend;
  always_comb begin
    w_state      = r_state;
    w_valid      = r_valid;
    w_data       = r_data;
    w_wlast      = r_wlast;
    w_close_pend = r_close_pend;
    w_inc        = 1'b0;
    w_ovf        = r_ovf | (w_inwin & ((r_state == HDR0) | (r_state == HDR1) |
                   ((r_state == CAPT) & (~w_free | w_closing))));
    case (r_state)
      IDLE: begin
        w_close_pend = 1'b0;
        if (w_start) w_state = r_mask[sector] ? HDR0 : SKIP;
      end
      HDR0: begin
        if (!r_valid) begin
          w_valid = 1'b1;
          w_data  = {4'hA, r_bear_l};
        end else if (w_hs) begin
          w_state = HDR1;
          w_data  = r_sweep_cnt;
        end
      end
      HDR1: begin
        if (w_hs) begin
          w_state = CAPT;
          w_valid = 1'b0;
        end
      end
      CAPT: begin
        if (w_hs & r_wlast) begin
          w_state = IDLE;
          w_valid = 1'b0;
          w_wlast = 1'b0;
          w_inc   = 1'b1;
        end else if (w_closing & w_free) begin
          w_state      = CLOSE;
          w_valid      = 1'b1;
          w_data       = 16'hE000;
          w_wlast      = 1'b1;
          w_close_pend = 1'b0;
        end else if (w_closing) begin
          w_close_pend = 1'b1;
        end else if (w_inwin & w_free) begin
          w_valid = 1'b1;
          w_data  = {4'h0, r_adc};
          w_wlast = r_rng == r_last;
        end else if (w_hs) begin
          w_valid = 1'b0;
        end
      end
      CLOSE: begin
        if (w_hs) begin
          w_state = IDLE;
          w_valid = 1'b0;
          w_wlast = 1'b0;
          w_inc   = 1'b1;
        end
      end
      SKIP: w_state = pros ? SKIP : IDLE;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_pros_q     <= 1'b0;
      r_dv         <= 1'b0;
      r_rng        <= '0;
      r_adc        <= '0;
      r_bear_l     <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_wlast      <= 1'b0;
      r_close_pend <= 1'b0;
      r_ovf        <= 1'b0;
      r_mask       <= '1;
      r_first      <= '0;
      r_last       <= '1;
      r_cfg_pend   <= 1'b0;
      r_sweep_cnt  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state;
      r_pros_q     <= pros;
      r_dv         <= adc_dv;
      r_rng        <= range;
      r_adc        <= adc_data;
      r_valid      <= w_valid;
      r_data       <= w_data;
      r_wlast      <= w_wlast;
      r_close_pend <= w_close_pend;
      r_ovf        <= w_ovf;
      r_sweep_cnt  <= north ? '0 : r_sweep_cnt + 16'(w_inc);
      if (w_idle && w_start) r_bear_l <= bear;
      if (w_idle && (cfg_load || r_cfg_pend)) begin
        r_mask     <= cfg_sector_mask;
        r_first    <= cfg_rng_first;
        r_last     <= cfg_rng_last;
        r_cfg_pend <= 1'b0;
      end else if (cfg_load) begin
        r_cfg_pend <= 1'b1;
      end
      if (w_start && !w_idle && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
  assign wr.wr_valid = r_valid;
  assign wr.wr_data  = r_data;
  assign wr.wr_last  = r_wlast;
  assign sweep_cnt   = r_sweep_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign ovf         = r_ovf;
  assign busy        = !w_idle;
endmodule

// File: tb/tb_sweep_sched.sv
// tb_sweep_sched: directed and randomized sweeps checked against a frame-level model
// that lists the words each recorded sweep must produce.
module tb_sweep_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_sector_mask;
  logic [9:0]  cfg_rng_first, cfg_rng_last;
  logic        cfg_load, north, pros, adc_dv;
  logic [3:0]  sector;
  logic [11:0] bear, adc_data;
  logic [9:0]  range;
  logic [15:0] sweep_cnt;
  logic [7:0]  drop_cnt;
  logic        ovf, busy;
  sweep_sched_if wr_if();
  sweep_sched dut (
    .clk(clk), .reset(rst_n), .cfg_sector_mask(cfg_sector_mask),
    .cfg_rng_first(cfg_rng_first), .cfg_rng_last(cfg_rng_last), .cfg_load(cfg_load),
    .sector(sector), .bear(bear), .north(north), .pros(pros), .range(range),
    .adc_dv(adc_dv), .adc_data(adc_data), .wr(wr_if), .sweep_cnt(sweep_cnt),
    .drop_cnt(drop_cnt), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [16:0] got[$];
  logic [16:0] exp[$];
  int          sr[$];
  logic [11:0] sd[$];
  int          checks = 0, errors = 0;
  logic [15:0] m_mask, m_cnt;
  int          m_first, m_last;
  bit          mid_load;
  always @(negedge clk)
    if (rst_n && wr_if.wr_valid && wr_if.wr_ready) got.push_back({wr_if.wr_last, wr_if.wr_data});
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, a, e);
    end
  endtask
  task automatic set_cfg(input logic [15:0] msk, input int f, input int l);
    cfg_sector_mask = msk;
    cfg_rng_first = 10'(f);
    cfg_rng_last = 10'(l);
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    m_mask = msk;
    m_first = f;
    m_last = l;
  endtask
  task automatic drive_samples(input int nb);
    for (int r = 0; r < nb; r++) begin
      range = 10'(r);
      adc_data = 12'($urandom_range(0, 4095));
      adc_dv = 1'b1;
      cfg_load = mid_load && r == 2;
      sr.push_back(r);
      sd.push_back(adc_data);
      tick;
      adc_dv = 1'b0;
      cfg_load = 1'b0;
      tick;
    end
  endtask
  // Expected frame: header, in-window bins in order up to the last bin, else a CLOSE word
  task automatic build_exp(input logic [11:0] b);
    bit done = 0;
    exp.push_back({1'b0, 4'hA, b});
    exp.push_back({1'b0, m_cnt});
    foreach (sr[i])
      if (!done && sr[i] >= m_first && sr[i] <= m_last) begin
        exp.push_back({sr[i] == m_last, 4'h0, sd[i]});
        done = sr[i] == m_last;
      end
    if (!done) exp.push_back({1'b1, 16'hE000});
  endtask
  task automatic compare_frame(input string tag);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    got.delete();
    exp.delete();
    sr.delete();
    sd.delete();
  endtask
  task automatic wait_idle;
    int n = 0;
    while (busy && n < 60) begin
      tick;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  task automatic sweep(input string tag, input logic [11:0] b, input logic [3:0] s, input int nb);
    logic rec;
    rec = m_mask[s];
    bear = b;
    sector = s;
    pros = 1'b1;
    tick;
    tick;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_hdr0_valid"}, wr_if.wr_valid, rec);
    if (rec) chk({tag, "_hdr0_word"}, wr_if.wr_data, {4'hA, b});
    tick;
    if (rec) chk({tag, "_hdr1_word"}, wr_if.wr_data, m_cnt);
    repeat (3) tick;
    drive_samples(nb);
    repeat (2) tick;
    pros = 1'b0;
    wait_idle;
    tick;
    if (rec) begin
      build_exp(b);
      m_cnt++;
    end
    compare_frame(tag);
    chk({tag, "_sweep_cnt"}, sweep_cnt, m_cnt);
    if (mid_load) begin
      m_mask = cfg_sector_mask;
      m_first = cfg_rng_first;
      m_last = cfg_rng_last;
      mid_load = 0;
    end
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    {pros, north, adc_dv, cfg_load} = '0;
    range = '0;
    adc_data = '0;
    bear = '0;
    sector = '0;
    cfg_sector_mask = '1;
    cfg_rng_first = '0;
    cfg_rng_last = '0;
    wr_if.wr_ready = 1'b1;
    m_mask = 16'hFFFF;
    m_first = 0;
    m_last = 1023;
    m_cnt = '0;
    mid_load = 0;
    repeat (3) tick;
    chk("rst_valid", wr_if.wr_valid, 0);
    chk("rst_data", wr_if.wr_data, 0);
    chk("rst_last", wr_if.wr_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sweep_cnt", sweep_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    tick;
    set_cfg(16'hFFFF, 2, 5);
    sweep("basic", 12'h123, 4'd0, 10);
    set_cfg(16'hFFF7, 0, 1023);
    sweep("masked", 12'h055, 4'd3, 6);
    chk("masked_drop", drop_cnt, 0);
    set_cfg(16'hFFFF, 3, 1000);
    sweep("early_drop", 12'h7FF, 4'd2, 11);
    north = 1'b1;
    tick;
    north = 1'b0;
    m_cnt = '0;
    chk("north_clear", sweep_cnt, 0);
    set_cfg(16'hFFFF, 1, 4);
    sweep("north_a", 12'h201, 4'd4, 6);
    sweep("north_b", 12'h202, 4'd4, 6);
    cfg_sector_mask = 16'hFFFF;
    cfg_rng_first = 10'd6;
    cfg_rng_last = 10'd8;
    mid_load = 1;
    sweep("cfg_mid_old", 12'h0AA, 4'd5, 10);
    sweep("cfg_mid_new", 12'h0BB, 4'd5, 10);
    set_cfg(16'hFFFF, 2, 5);
    wr_if.wr_ready = 1'b0;
    bear = 12'h321;
    sector = 4'd1;
    pros = 1'b1;
    tick;
    tick;
    chk("ovl_hdr0_valid", wr_if.wr_valid, 1);
    wr_if.wr_ready = 1'b1;
    tick;
    wr_if.wr_ready = 1'b0;
    pros = 1'b0;
    tick;
    pros = 1'b1;
    tick;
    chk("ovl_drop", drop_cnt, 1);
    chk("ovl_hdr1_held", wr_if.wr_data, m_cnt);
    wr_if.wr_ready = 1'b1;
    repeat (3) tick;
    drive_samples(8);
    repeat (2) tick;
    pros = 1'b0;
    wait_idle;
    tick;
    build_exp(12'h321);
    m_cnt++;
    compare_frame("overlap");
    chk("ovl_sweep_cnt", sweep_cnt, m_cnt);
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        north = 1'b1;
        tick;
        north = 1'b0;
        m_cnt = '0;
      end
      set_cfg(16'($urandom), $urandom_range(0, 12), $urandom_range(0, 14));
      sweep("rand", 12'($urandom), 4'($urandom), $urandom_range(4, 16));
    end
    chk("pre_bp_ovf", ovf, 0);
    chk("pre_bp_drop", drop_cnt, 1);
    set_cfg(16'hFFFF, 0, 20);
    bear = 12'h4C4;
    sector = 4'd0;
    pros = 1'b1;
    tick;
    repeat (5) tick;
    wr_if.wr_ready = 1'b0;
    drive_samples(4);
    chk("bp_ovf", ovf, 1);
    chk("bp_valid", wr_if.wr_valid, 1);
    chk("bp_held", wr_if.wr_data, {4'h0, sd[0]});
    exp.push_back({1'b0, 4'hA, 12'h4C4});
    exp.push_back({1'b0, m_cnt});
    exp.push_back({1'b0, 4'h0, sd[0]});
    exp.push_back({1'b1, 16'hE000});
    wr_if.wr_ready = 1'b1;
    repeat (3) tick;
    pros = 1'b0;
    wait_idle;
    tick;
    m_cnt++;
    compare_frame("backpressure");
    chk("bp_sweep_cnt", sweep_cnt, m_cnt);
    wr_if.wr_ready = 1'b0;
    pros = 1'b1;
    tick;
    tick;
    chk("rstmid_valid_before", wr_if.wr_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("rstmid_valid", wr_if.wr_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ovf", ovf, 0);
    chk("rstmid_sweep_cnt", sweep_cnt, 0);
    chk("rstmid_drop_cnt", drop_cnt, 0);
    tick;
    wr_if.wr_ready = 1'b1;
    pros = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick;
    chk("rstmid_no_words", got.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
